// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the hazard controller's decode/execute/memory observation inputs and its
// pipeline-register control outputs into one interface.
//   master : the datapath side; drives the observed instruction fields and handshakes,
//            receives the write-enable / flush / bubble / exception controls.
//   slave  : the hazard controller itself.
// Signals
//   id_rs, id_rt, id_uses_rt, id_jump, eret   instruction currently in ID
//   ex_mem_read, ex_rd, ex_branch_tk           instruction currently in EX
//   mem_req, mem_ack                           data-memory access of the instruction in MEM
//   irq                                        level interrupt request
//   pc_write .. memwb_bubble                   pipeline register / PC controls
//   exc_take                                   selects the exception vector for the PC
//   bus_err                                    sticky data-memory timeout flag
//   stall_cnt                                  saturating count of PC-stall cycles
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic             ex_branch_tk;
   logic             mem_req;
   logic             mem_ack;
   logic             irq;
   logic             eret;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_flush;
   logic             exmem_write;
   logic             exmem_flush;
   logic             memwb_bubble;
   logic             exc_take;
   logic             bus_err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rd, ex_branch_tk,
             mem_req, mem_ack, irq, eret,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
             exmem_flush, memwb_bubble, exc_take, bus_err, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rd, ex_branch_tk,
             mem_req, mem_ack, irq, eret,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
             exmem_flush, memwb_bubble, exc_take, bus_err, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Detects load-use hazards, taken branches, jumps, multi-cycle data-memory accesses and
// interrupts, and drives per-stage write-enable, flush and bubble controls (Mealy, so a
// stall or flush takes effect at the very next clock edge) plus a saturating stall counter.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    pipeline_hazard_ctrl_if.slave (see the interface for the signal list)
// Parameters
//   MEM_TIMEOUT  cycles spent in MEM_WAIT without mem_ack before bus_err is raised (>=2)
//   CNT_W        width of stall_cnt; must match the interface instance
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      EXC_DRAIN
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_irqEn;
   logic             w_irqEnNext;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [WAIT_W-1:0] w_waitCntNext;
   logic             r_busErr;
   logic             w_busErrNext;
   logic [CNT_W-1:0] r_stallCnt;

   logic w_loadUse;
   logic w_pcWrite;
   logic w_ifidWrite;
   logic w_ifidFlush;
   logic w_idexWrite;
   logic w_idexFlush;
   logic w_exmemWrite;
   logic w_exmemFlush;
   logic w_memwbBubble;
   logic w_excTake;

   // A load in EX whose destination feeds the instruction in ID cannot be forwarded in
   // time; $0 is never a real dependency.
   assign w_loadUse = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

   // State, interrupt enable, wait counter and sticky bus error.  Everything returns to
   // the idle RUN condition as soon as reset drops, abandoning any pending access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= RUN;
         r_irqEn   <= 1'b1;
         r_waitCnt <= '0;
         r_busErr  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_irqEn   <= w_irqEnNext;
         r_waitCnt <= w_waitCntNext;
         r_busErr  <= w_busErrNext;
      end
   end

   // Counts every cycle the PC is held, sticking at all-ones instead of wrapping so a
   // long-running profile never reads back as small.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stallCnt <= '0;
      end else if (!w_pcWrite && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   // Next-state and Mealy outputs.  Defaults let the whole pipeline advance; events in RUN
   // are prioritised memory wait, interrupt, branch, jump, load-use.  Flushes leave the
   // stage write enable high so the register actually loads the bubble.  eret re-arms
   // interrupts unless an interrupt is taken in the same cycle.  While reset is low all
   // controls are forced off so nothing in the datapath moves.
   always_comb begin
      w_nextState   = r_state;
      w_irqEnNext   = r_irqEn;
      w_waitCntNext = r_waitCnt;
      w_busErrNext  = r_busErr;
      w_pcWrite     = 1'b1;
      w_ifidWrite   = 1'b1;
      w_ifidFlush   = 1'b0;
      w_idexWrite   = 1'b1;
      w_idexFlush   = 1'b0;
      w_exmemWrite  = 1'b1;
      w_exmemFlush  = 1'b0;
      w_memwbBubble = 1'b0;
      w_excTake     = 1'b0;

      case (r_state)
         RUN: begin
            if (bus.eret) begin
               w_irqEnNext = 1'b1;
            end
            if (bus.mem_req && !bus.mem_ack) begin
               w_pcWrite     = 1'b0;
               w_ifidWrite   = 1'b0;
               w_idexWrite   = 1'b0;
               w_exmemWrite  = 1'b0;
               w_memwbBubble = 1'b1;
               w_waitCntNext = WAIT_W'(1);
               w_nextState   = MEM_WAIT;
            end else if (bus.irq && r_irqEn) begin
               w_excTake    = 1'b1;
               w_ifidFlush  = 1'b1;
               w_idexFlush  = 1'b1;
               w_exmemFlush = 1'b1;
               w_irqEnNext  = 1'b0;
               w_nextState  = EXC_DRAIN;
            end else if (bus.ex_branch_tk) begin
               w_ifidFlush = 1'b1;
               w_idexFlush = 1'b1;
            end else if (bus.id_jump) begin
               w_ifidFlush = 1'b1;
            end else if (w_loadUse) begin
               w_pcWrite   = 1'b0;
               w_ifidWrite = 1'b0;
               w_idexFlush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ack) begin
               w_waitCntNext = '0;
               w_nextState   = RUN;
            end else begin
               w_pcWrite     = 1'b0;
               w_ifidWrite   = 1'b0;
               w_idexWrite   = 1'b0;
               w_exmemWrite  = 1'b0;
               w_memwbBubble = 1'b1;
               if (r_waitCnt == WAIT_W'(MEM_TIMEOUT)) begin
                  w_busErrNext  = 1'b1;
                  w_waitCntNext = '0;
                  w_nextState   = RUN;
               end else begin
                  w_waitCntNext = r_waitCnt + WAIT_W'(1);
               end
            end
         end
         EXC_DRAIN: begin
            w_nextState = RUN;
         end
         default: begin
            w_nextState = RUN;
         end
      endcase

      if (!reset) begin
         w_pcWrite     = 1'b0;
         w_ifidWrite   = 1'b0;
         w_ifidFlush   = 1'b0;
         w_idexWrite   = 1'b0;
         w_idexFlush   = 1'b0;
         w_exmemWrite  = 1'b0;
         w_exmemFlush  = 1'b0;
         w_memwbBubble = 1'b0;
         w_excTake     = 1'b0;
      end
   end

   assign bus.pc_write     = w_pcWrite;
   assign bus.ifid_write   = w_ifidWrite;
   assign bus.ifid_flush   = w_ifidFlush;
   assign bus.idex_write   = w_idexWrite;
   assign bus.idex_flush   = w_idexFlush;
   assign bus.exmem_write  = w_exmemWrite;
   assign bus.exmem_flush  = w_exmemFlush;
   assign bus.memwb_bubble = w_memwbBubble;
   assign bus.exc_take     = w_excTake;
   assign bus.bus_err      = r_busErr;
   assign bus.stall_cnt    = r_stallCnt;
endmodule
